// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, funct3 and opcode constants for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: funct3/lane decode into legality, alignment, byte enables, replicated write data and extended load data
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic        legal,
  output logic        aligned
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = lane[1] ? (lane[0] ? rdata[31:24] : rdata[23:16]) : (lane[0] ? rdata[15:8] : rdata[7:0]);
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    legal = is_store ? funct3 inside {F3_SB, F3_SH, F3_SW} : funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    aligned = funct3[1:0] == 2'b00 || (funct3[1:0] == 2'b01 && !lane[0]) || lane == 2'b00;
    be = !is_store ? 4'hf : funct3[1:0] == 2'b00 ? 4'b0001 << lane : funct3[1:0] == 2'b01 ? 4'b0011 << lane : 4'hf;
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    load_result = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                  funct3 == F3_LBU ? {24'b0, b} :
                  funct3 == F3_LH  ? {{16{h[15]}}, h} :
                  funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store execution as req/ack bus transactions with stall, fault and timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] load_result,
  output logic        load_valid,
  output logic        fault
);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  lsu_state_t  state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] load_result_q, load_result_d, cnt_q, cnt_d;
  logic        load_valid_q, load_valid_d, fault_q, fault_d;
  logic        idle, req, go, legal, aligned;
  logic [31:0] addr, wdata, ext;
  logic [3:0]  be;
  assign idle = state_q == IDLE;
  assign req  = load_en | store_en;
  assign addr = store_en ? write_address : read_address;
  assign go   = idle & req & legal & aligned;
  lsu_lane_align u_align (
    .is_store    (idle ? store_en : mem_we_q),
    .funct3      (idle ? funct3 : f3_q),
    .lane        (idle ? addr[1:0] : lane_q),
    .store_data  (store_data),
    .rdata       (mem_rdata),
    .be          (be),
    .wdata       (wdata),
    .load_result (ext),
    .legal       (legal),
    .aligned     (aligned)
  );
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    f3_d          = f3_q;
    lane_d        = lane_q;
    load_result_d = load_result_q;
    cnt_d         = cnt_q;
    load_valid_d  = 1'b0;
    fault_d       = 1'b0;
    case (state_q)
      IDLE: begin
        fault_d = req & ~go;
        if (go) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = store_en;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = be;
          mem_wdata_d = wdata;
          f3_d        = funct3;
          lane_d      = addr[1:0];
          cnt_d       = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d       = DONE;
          mem_req_d     = 1'b0;
          load_valid_d  = ~mem_we_q;
          load_result_d = mem_we_q ? load_result_q : ext;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      f3_q          <= '0;
      lane_q        <= '0;
      load_result_q <= '0;
      cnt_q         <= '0;
      load_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      f3_q          <= f3_d;
      lane_q        <= lane_d;
      load_result_q <= load_result_d;
      cnt_q         <= cnt_d;
      load_valid_q  <= load_valid_d;
      fault_q       <= fault_d;
    end
  end
  assign stall       = go | (state_q == REQ);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign load_result = load_result_q;
  assign load_valid  = load_valid_q;
  assign fault       = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, randomized model comparison and multi-cycle corner sequences for load_store_unit
module tb_load_store_unit;
  logic        clk, nRst, load_en, store_en, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, store_data, mem_rdata;
  logic        mem_req, mem_we, stall, load_valid, fault;
  logic [31:0] mem_addr, mem_wdata, load_result;
  logic [3:0]  mem_be;
  int          errors = 0, checks = 0;
  logic [31:0] last_res = '0;
  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] ra, wa, sd, rd;
    logic        go, flt, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd, res;
  } vec_t;
  vec_t tbl[13];
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nRst(nRst), .load_en(load_en), .store_en(store_en), .funct3(funct3),
    .read_address(read_address), .write_address(write_address), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .load_result(load_result),
    .load_valid(load_valid), .fault(fault)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    int sz;
    logic [31:0] a, m, s;
    logic lg;
    sz = v.f3[1:0] == 2'd0 ? 1 : v.f3[1:0] == 2'd1 ? 2 : v.f3[1:0] == 2'd2 ? 4 : 0;
    a = v.st ? v.wa : v.ra;
    lg = v.st ? v.f3 inside {3'd0, 3'd1, 3'd2} : v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    lg = lg && sz != 0 && (a % sz) == 0;
    model = v;
    model.we = v.st;
    model.go = (v.ld | v.st) && lg;
    model.flt = (v.ld | v.st) && !lg;
    model.addr = a & ~32'd3;
    model.be = v.st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hf;
    model.wd = sz == 1 ? v.sd[7:0] * 32'h01010101 : sz == 2 ? v.sd[15:0] * 32'h00010001 : v.sd;
    m = 32'((64'd1 << (8 * sz)) - 1);
    s = (v.rd >> (8 * (a % 4))) & m;
    if (!v.f3[2] && sz > 0 && sz < 4 && s[8 * sz - 1]) s = s | ~m;
    model.res = s;
  endfunction
  task automatic run(input vec_t v, input int ackd);
    @(negedge clk);
    load_en = v.ld; store_en = v.st; funct3 = v.f3;
    read_address = v.ra; write_address = v.wa; store_data = v.sd;
    #1 chk("stall_issue", stall, v.go);
    @(negedge clk);
    load_en = 0; store_en = 0;
    chk("fault", fault, v.flt);
    chk("mem_req_rise", mem_req, v.go);
    if (v.go) begin
      chk("mem_we", mem_we, v.we);
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_be", mem_be, v.be);
      if (v.we) chk("mem_wdata", mem_wdata, v.wd);
      repeat (ackd) begin
        @(negedge clk);
        chk("mem_req_hold", mem_req, 1);
        chk("stall_req", stall, 1);
      end
      mem_ack = 1; mem_rdata = v.rd;
      @(negedge clk);
      mem_ack = 0; mem_rdata = $urandom;
      chk("mem_req_drop", mem_req, 0);
      chk("stall_done", stall, 0);
      chk("load_valid", load_valid, !v.we);
      if (!v.we) last_res = v.res;
      chk("load_result", load_result, last_res);
      @(negedge clk);
      chk("load_valid_pulse", load_valid, 0);
    end
  endtask
  initial begin
    tbl[0]  = '{1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 1, 0, 0, 32'h100, 4'hf, 0, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF0000, 1, 0, 0, 32'h100, 4'hf, 0, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF0000, 1, 0, 0, 32'h100, 4'hf, 0, 32'h00000080};
    tbl[3]  = '{0, 1, 3'b001, 0, 32'h202, 32'h1234ABCD, 0, 1, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0};
    tbl[4]  = '{1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 3'b010, 32'h300, 32'h404, 32'hCAFEF00D, 0, 1, 0, 1, 32'h404, 4'hf, 32'hCAFEF00D, 0};
    tbl[7]  = '{0, 1, 3'b000, 0, 32'h001, 32'h00000055, 0, 1, 0, 1, 32'h000, 4'b0010, 32'h55555555, 0};
    tbl[8]  = '{1, 0, 3'b001, 32'h102, 0, 0, 32'h80010000, 1, 0, 0, 32'h100, 4'hf, 0, 32'hFFFF8001};
    tbl[9]  = '{1, 0, 3'b101, 32'h102, 0, 0, 32'h80010000, 1, 0, 0, 32'h100, 4'hf, 0, 32'h00008001};
    tbl[10] = '{0, 1, 3'b010, 0, 32'h202, 32'h11111111, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 3'b100, 0, 32'h200, 32'h11111111, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 3'b010, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    nRst = 0; load_en = 0; store_en = 0; funct3 = 0; mem_ack = 0;
    read_address = 0; write_address = 0; store_data = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {mem_req, mem_we, mem_be, load_valid, fault, stall}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_result", load_result, 0);
    nRst = 1;
    for (int i = 0; i < 13; i++) run(tbl[i], i % 3);
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v = tbl[12];
      v.ld = 1'($urandom); v.st = ($urandom % 4) == 0; v.f3 = 3'($urandom);
      v.ra = $urandom; v.wa = $urandom; v.sd = $urandom; v.rd = $urandom;
      run(model(v), $urandom_range(0, 3));
    end
    @(negedge clk);
    load_en = 1; funct3 = 3'b010; read_address = 32'h40;
    @(negedge clk);
    load_en = 0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req_high", mem_req, 1);
      @(negedge clk);
    end
    chk("tmo_req_drop", mem_req, 0);
    chk("tmo_fault", fault, 1);
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_valid", load_valid, 0);
    chk("late_ack_fault", fault, 0);
    chk("late_ack_result", load_result, last_res);
    @(negedge clk);
    load_en = 1; funct3 = 3'b010; read_address = 32'h100;
    @(negedge clk);
    load_en = 0;
    chk("mid_req_up", mem_req, 1);
    #2 nRst = 0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_outputs", {mem_we, mem_be, load_valid, fault}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_result", load_result, 0);
    @(negedge clk);
    nRst = 1;
    last_res = 0;
    @(negedge clk);
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_fault", fault, 0);
    run(tbl[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
